// File: rtl/configurations_pkg.sv
// Shared configuration for the vector memory path: element width and maximum vector length.
package configurations_pkg;
    localparam int DATA_WIDTH    = 32;
    localparam int VECTOR_LENGTH = 1024;
    localparam int VLEN_W        = $clog2(VECTOR_LENGTH) + 1;
endpackage

// File: rtl/v_addr_gen.sv
// Strided address accumulator plus issue counter for one vector transfer.
module v_addr_gen
    import configurations_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              advance,
    input  logic [31:0]       base,
    input  logic [31:0]       stride,
    input  logic [VLEN_W-1:0] len,
    output logic [31:0]       addr,
    output logic              last
);
    logic [31:0]       r_acc;
    logic [31:0]       r_stride;
    logic [VLEN_W-1:0] r_cnt;
    logic [VLEN_W-1:0] r_len;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc    <= '0;
            r_stride <= '0;
            r_cnt    <= '0;
            r_len    <= '0;
        end else if (load) begin
            r_acc    <= base;
            r_stride <= stride;
            r_cnt    <= '0;
            r_len    <= len;
        end else if (advance) begin
            // 32-bit add wraps silently; a negative stride is just its two's complement
            r_acc <= r_acc + r_stride;
            r_cnt <= r_cnt + VLEN_W'(1);
        end
    end

    assign addr = r_acc;
    // High while the element about to be issued is the final one
    assign last = (r_cnt == r_len - VLEN_W'(1));
endmodule

// File: rtl/v_mem_ctrl.sv
// Vector load/store controller: strided element transfers between lane FIFOs and data memory.
module v_mem_ctrl
    import configurations_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_i,
    input  logic                  is_store_i,
    input  logic [31:0]           base_addr_i,
    input  logic [31:0]           stride_i,
    input  logic [VLEN_W-1:0]     vector_length_i,
    output logic                  ready_o,
    output logic                  done_o,
    output logic [31:0]           mem_addr_o,
    output logic                  mem_re_o,
    output logic                  mem_we_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output logic                  load_fifo_we_o,
    output logic [DATA_WIDTH-1:0] data_from_mem_o,
    input  logic                  load_fifo_almostfull_i,
    output logic                  store_fifo_re_o,
    input  logic [DATA_WIDTH-1:0] data_to_mem_i,
    input  logic                  store_fifo_empty_i
);
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_STORE, S_DRAIN} state_t;

    state_t            r_state;
    state_t            w_next;
    logic [VLEN_W-1:0] w_len;
    logic              w_start;
    logic              w_last;
    logic              w_issue_ld;
    logic              w_issue_st;
    logic [31:0]       w_addr;
    logic [31:0]       r_wb_addr;
    logic              r_ld_wb;
    logic              r_st_wb;

    assign w_len   = (vector_length_i > VLEN_W'(VECTOR_LENGTH)) ? VLEN_W'(VECTOR_LENGTH)
                                                                  : vector_length_i;
    assign w_start = (r_state == S_IDLE) && start_i;

    v_addr_gen u_addr_gen (
        .clk     (clk),
        .reset   (reset),
        .load    (w_start),
        .advance (w_issue_ld | w_issue_st),
        .base    (base_addr_i),
        .stride  (stride_i),
        .len     (w_len),
        .addr    (w_addr),
        .last    (w_last)
    );

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Leaving on the final issue puts its writeback in the single DRAIN cycle
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start_i) w_next = (w_len == '0) ? S_DRAIN : (is_store_i ? S_STORE : S_LOAD);
            S_LOAD:  if (w_issue_ld && w_last) w_next = S_DRAIN;
            S_STORE: if (w_issue_st && w_last) w_next = S_DRAIN;
            default: w_next = S_IDLE;
        endcase
    end

    // Strobes are gated by reset so nothing leaks out during the reset cycle itself
    always_comb begin
        ready_o         = (r_state == S_IDLE);
        done_o          = !reset && (r_state == S_DRAIN);
        w_issue_ld      = !reset && (r_state == S_LOAD)  && !load_fifo_almostfull_i;
        w_issue_st      = !reset && (r_state == S_STORE) && !store_fifo_empty_i;
        mem_re_o        = w_issue_ld;
        store_fifo_re_o = w_issue_st;
        mem_we_o        = !reset && r_st_wb;
        load_fifo_we_o  = !reset && r_ld_wb;
        mem_addr_o      = '0;
        if (mem_re_o)      mem_addr_o = w_addr;
        else if (mem_we_o) mem_addr_o = r_wb_addr;
        mem_wdata_o     = mem_we_o       ? data_to_mem_i : '0;
        data_from_mem_o = load_fifo_we_o ? mem_rdata_i   : '0;
    end

    // Store address is latched at FIFO-pop time so it pairs with the data arriving next cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ld_wb   <= 1'b0;
            r_st_wb   <= 1'b0;
            r_wb_addr <= '0;
        end else begin
            r_ld_wb <= w_issue_ld;
            r_st_wb <= w_issue_st;
            if (w_issue_st) r_wb_addr <= w_addr;
        end
    end
endmodule

// File: tb/tb_v_mem_ctrl.sv
// Directed bench for v_mem_ctrl: cycle-by-cycle strobe/address/data expectations per scenario.
module tb_v_mem_ctrl;
    import configurations_pkg::*;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  start_i;
    logic                  is_store_i;
    logic [31:0]           base_addr_i;
    logic [31:0]           stride_i;
    logic [VLEN_W-1:0]     vector_length_i;
    logic                  ready_o;
    logic                  done_o;
    logic [31:0]           mem_addr_o;
    logic                  mem_re_o;
    logic                  mem_we_o;
    logic [DATA_WIDTH-1:0] mem_wdata_o;
    logic [DATA_WIDTH-1:0] mem_rdata_i = '0;
    logic                  load_fifo_we_o;
    logic [DATA_WIDTH-1:0] data_from_mem_o;
    logic                  load_fifo_almostfull_i;
    logic                  store_fifo_re_o;
    logic [DATA_WIDTH-1:0] data_to_mem_i = '0;
    logic                  store_fifo_empty_i;

    int checks = 0;
    int errors = 0;
    int fifo_idx = 0;

    v_mem_ctrl dut (
        .clk                    (clk),
        .reset                  (reset),
        .start_i                (start_i),
        .is_store_i             (is_store_i),
        .base_addr_i            (base_addr_i),
        .stride_i               (stride_i),
        .vector_length_i        (vector_length_i),
        .ready_o                (ready_o),
        .done_o                 (done_o),
        .mem_addr_o             (mem_addr_o),
        .mem_re_o               (mem_re_o),
        .mem_we_o               (mem_we_o),
        .mem_wdata_o            (mem_wdata_o),
        .mem_rdata_i            (mem_rdata_i),
        .load_fifo_we_o         (load_fifo_we_o),
        .data_from_mem_o        (data_from_mem_o),
        .load_fifo_almostfull_i (load_fifo_almostfull_i),
        .store_fifo_re_o        (store_fifo_re_o),
        .data_to_mem_i          (data_to_mem_i),
        .store_fifo_empty_i     (store_fifo_empty_i)
    );

    always #5 clk = ~clk;

    // Memory returns addr^A5A50000 one cycle after a read; store FIFO pops D0000000, D0000001, ...
    always @(posedge clk) begin
        if (mem_re_o) mem_rdata_i <= mem_addr_o ^ 32'hA5A5_0000;
        if (store_fifo_re_o) begin
            data_to_mem_i <= 32'hD000_0000 + 32'(fifo_idx);
            fifo_idx      <= fifo_idx + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // flags = {ready, done, mem_re, mem_we, load_fifo_we, store_fifo_re}
    task automatic cyc(input string tag, input logic [5:0] f, input logic [31:0] a);
        #1;
        chk({tag, " flags"}, 32'({ready_o, done_o, mem_re_o, mem_we_o, load_fifo_we_o, store_fifo_re_o}),
            32'(f));
        chk({tag, " addr"}, mem_addr_o, a);
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n_we;
        int done_at;
        reset = 1'b1; start_i = 1'b0; is_store_i = 1'b0;
        base_addr_i = '0; stride_i = '0; vector_length_i = '0;
        load_fifo_almostfull_i = 1'b0; store_fifo_empty_i = 1'b0;
        nxt(); nxt();
        cyc("rst", 6'b100000, 32'h0);
        chk("rst wdata", mem_wdata_o, 32'h0);
        chk("rst ldata", data_from_mem_o, 32'h0);
        reset = 1'b0;
        nxt(); cyc("idle", 6'b100000, 32'h0);

        // Load len=4, base 0x100, stride 4; start held high for two extra edges must be ignored
        start_i = 1'b1; is_store_i = 1'b0; base_addr_i = 32'h100; stride_i = 32'd4; vector_length_i = 11'd4;
        nxt(); base_addr_i = 32'h900;
        cyc("A1", 6'b001000, 32'h100);
        nxt(); cyc("A2", 6'b001010, 32'h104); chk("A2 data", data_from_mem_o, 32'hA5A5_0100);
        nxt(); start_i = 1'b0;
        cyc("A3", 6'b001010, 32'h108); chk("A3 data", data_from_mem_o, 32'hA5A5_0104);
        nxt(); cyc("A4", 6'b001010, 32'h10C); chk("A4 data", data_from_mem_o, 32'hA5A5_0108);
        nxt(); cyc("A5", 6'b010010, 32'h0);   chk("A5 data", data_from_mem_o, 32'hA5A5_010C);
        nxt(); cyc("A6", 6'b100000, 32'h0);

        // Store len=3, base 0x20, stride -8, FIFO empty in cycle 2
        start_i = 1'b1; is_store_i = 1'b1; base_addr_i = 32'h20; stride_i = 32'hFFFF_FFF8; vector_length_i = 11'd3;
        nxt(); start_i = 1'b0; is_store_i = 1'b0;
        cyc("B1", 6'b000001, 32'h0);
        nxt(); store_fifo_empty_i = 1'b1;
        cyc("B2", 6'b000100, 32'h20); chk("B2 wdata", mem_wdata_o, 32'hD000_0000);
        nxt(); store_fifo_empty_i = 1'b0;
        cyc("B3", 6'b000001, 32'h0);
        nxt(); cyc("B4", 6'b000101, 32'h18); chk("B4 wdata", mem_wdata_o, 32'hD000_0001);
        nxt(); cyc("B5", 6'b010100, 32'h10); chk("B5 wdata", mem_wdata_o, 32'hD000_0002);
        nxt(); cyc("B6", 6'b100000, 32'h0);

        // Zero-length transfer
        start_i = 1'b1; vector_length_i = 11'd0;
        nxt(); start_i = 1'b0;
        cyc("C1", 6'b010000, 32'h0);
        nxt(); cyc("C2", 6'b100000, 32'h0);

        // Load len=4, base 0x200, stride 0x10, almost-full in cycles 2-4
        start_i = 1'b1; base_addr_i = 32'h200; stride_i = 32'h10; vector_length_i = 11'd4;
        nxt(); start_i = 1'b0;
        cyc("D1", 6'b001000, 32'h200);
        nxt(); load_fifo_almostfull_i = 1'b1;
        cyc("D2", 6'b000010, 32'h0); chk("D2 data", data_from_mem_o, 32'hA5A5_0200);
        nxt(); cyc("D3", 6'b000000, 32'h0);
        nxt(); cyc("D4", 6'b000000, 32'h0);
        nxt(); load_fifo_almostfull_i = 1'b0;
        cyc("D5", 6'b001000, 32'h210);
        nxt(); cyc("D6", 6'b001010, 32'h220);
        nxt(); cyc("D7", 6'b001010, 32'h230);
        nxt(); cyc("D8", 6'b010010, 32'h0); chk("D8 data", data_from_mem_o, 32'hA5A5_0230);
        nxt(); cyc("D9", 6'b100000, 32'h0);

        // Address wrap-around
        start_i = 1'b1; base_addr_i = 32'hFFFF_FFFC; stride_i = 32'd4; vector_length_i = 11'd2;
        nxt(); start_i = 1'b0;
        cyc("E1", 6'b001000, 32'hFFFF_FFFC);
        nxt(); cyc("E2", 6'b001010, 32'h0); chk("E2 data", data_from_mem_o, 32'h5A5A_FFFC);
        nxt(); cyc("E3", 6'b010010, 32'h0); chk("E3 data", data_from_mem_o, 32'hA5A5_0000);
        nxt(); cyc("E4", 6'b100000, 32'h0);

        // Reset in cycle 3 of a len=8 load, then a fresh len=1 load
        start_i = 1'b1; base_addr_i = 32'h400; stride_i = 32'd4; vector_length_i = 11'd8;
        nxt(); start_i = 1'b0;
        cyc("F1", 6'b001000, 32'h400);
        nxt(); cyc("F2", 6'b001010, 32'h404);
        nxt(); reset = 1'b1;
        cyc("F3", 6'b000000, 32'h0);
        nxt(); reset = 1'b0;
        cyc("F4", 6'b100000, 32'h0);
        nxt(); cyc("F5", 6'b100000, 32'h0);
        start_i = 1'b1; base_addr_i = 32'h40; stride_i = 32'd4; vector_length_i = 11'd1;
        nxt(); start_i = 1'b0;
        cyc("F7", 6'b001000, 32'h40);
        nxt(); cyc("F8", 6'b010010, 32'h0); chk("F8 data", data_from_mem_o, 32'hA5A5_0040);
        nxt(); cyc("F9", 6'b100000, 32'h0);

        // Over-long length clamps to VECTOR_LENGTH elements
        start_i = 1'b1; base_addr_i = 32'h0; stride_i = 32'd4; vector_length_i = 11'd2000;
        nxt(); start_i = 1'b0;
        n_we = 0; done_at = 0;
        for (int c = 1; c <= 1100; c++) begin
            #1;
            if (load_fifo_we_o) n_we++;
            if (done_o && done_at == 0) done_at = c;
            nxt();
        end
        chk("G done cycle", 32'(done_at), 32'd1025);
        chk("G writebacks", 32'(n_we), 32'd1024);
        cyc("G idle", 6'b100000, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/v_mem_ctrl.md
V_MEM_CTRL -- requirements
Module: v_mem_ctrl

Interface
REQ-001 SHALL take parameters from configurations_pkg: DATA_WIDTH (default 32, element width in bits) and VECTOR_LENGTH (default 1024, maximum elements per vector).
REQ-002 SHALL have port clk, input, 1 bit: single clock; all logic on rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port start_i, input, 1 bit: request to begin a transfer; sampled only in IDLE.
REQ-005 SHALL have port is_store_i, input, 1 bit: 1 = store (lane to memory), 0 = load (memory to lane); captured with start_i.
REQ-006 SHALL have port base_addr_i, input, 32 bits: address of element 0; captured with start_i.
REQ-007 SHALL have port stride_i, input, 32 bits: signed two's-complement byte stride between elements; captured with start_i.
REQ-008 SHALL have port vector_length_i, input, $clog2(VECTOR_LENGTH)+1 bits: element count; captured with start_i.
REQ-009 SHALL have port ready_o, output, 1 bit: high only in IDLE.
REQ-010 SHALL have port done_o, output, 1 bit: one-cycle completion pulse.
REQ-011 SHALL have ports mem_addr_o (output, 32 bits), mem_re_o (output, 1 bit), mem_we_o (output, 1 bit), mem_wdata_o (output, DATA_WIDTH bits) and mem_rdata_i (input, DATA_WIDTH bits): data-memory port; read data is valid exactly 1 cycle after mem_re_o.
REQ-012 SHALL have ports load_fifo_we_o (output, 1 bit), data_from_mem_o (output, DATA_WIDTH bits) and load_fifo_almostfull_i (input, 1 bit): lane load-FIFO side.
REQ-013 SHALL have ports store_fifo_re_o (output, 1 bit), data_to_mem_i (input, DATA_WIDTH bits) and store_fifo_empty_i (input, 1 bit): lane store-FIFO side; read data is valid 1 cycle after store_fifo_re_o.

Function
REQ-014 SHALL implement the FSM states IDLE, LOAD, STORE and DRAIN.
REQ-015 SHALL, in IDLE with start_i=1, capture the inputs, clear the issue counter, set the address accumulator to base_addr_i, and go to LOAD or STORE; if the captured length is 0 it SHALL go directly to DRAIN.
REQ-016 SHALL clamp vector_length_i values greater than VECTOR_LENGTH to VECTOR_LENGTH.
REQ-017 SHALL, in LOAD, assert mem_re_o with mem_addr_o equal to the accumulator in any cycle where issued<len and load_fifo_almostfull_i=0; on each such issue it SHALL add stride to the accumulator and increment issued.
REQ-018 SHALL drive load_fifo_we_o as mem_re_o delayed by 1 cycle, with data_from_mem_o equal to mem_rdata_i in that cycle (no extra buffering).
REQ-019 SHALL, in STORE, assert store_fifo_re_o in any cycle where issued<len and store_fifo_empty_i=0, and increment issued on each such assertion.
REQ-020 SHALL, one cycle after each store_fifo_re_o, assert mem_we_o with mem_wdata_o equal to data_to_mem_i and mem_addr_o equal to the accumulator, then add stride to the accumulator.
REQ-021 SHALL leave LOAD or STORE for DRAIN in the cycle after issued reaches len.
REQ-022 SHALL assert done_o for exactly the one DRAIN cycle, which carries the final load_fifo_we_o or mem_we_o, then return to IDLE.
REQ-023 SHALL, with no stalls and len=N, produce: start at edge 0; issues in cycles 1..N; writebacks in cycles 2..N+1; done_o in cycle N+1; ready_o again in cycle N+2.
REQ-024 SHALL ignore start_i outside IDLE.
REQ-025 SHALL compute address arithmetic modulo 2^32, so wrap-around is silent.
REQ-026 SHALL never assert mem_re_o and mem_we_o in the same cycle.
REQ-027 SHALL, when a FIFO stall (almostfull or empty) occurs, only suppress new issues; an in-flight writeback SHALL still complete.

Reset
REQ-028 SHALL, on reset=1 at any clock edge, enter IDLE, clear the counter and accumulator, and drive ready_o=1 in the following cycle.
REQ-029 SHALL drive done_o, mem_re_o, mem_we_o, load_fifo_we_o and store_fifo_re_o to 0 during and after reset, and SHALL drive mem_addr_o, mem_wdata_o and data_from_mem_o to 0.
REQ-030 SHALL, on reset mid-transfer, abort the transfer with no done_o pulse and drop the pending writeback.

Structure
REQ-031 SHALL import DATA_WIDTH and VECTOR_LENGTH from configurations_pkg; the FSM state typedef SHALL be local to the module.
REQ-032 SHALL place the accumulator and issue counter in one sub-module, v_addr_gen, with inputs load, advance, base, stride and len, and outputs addr and last.

Verification
REQ-033 SHALL cover a load with len=4, base=0x100, stride=4: mem_addr_o=0x100/0x104/0x108/0x10C in cycles 1-4, load_fifo_we_o in cycles 2-5, done_o in cycle 5.
REQ-034 SHALL cover a store with len=3, stride=-8, base=0x20, with store_fifo_empty_i high in cycle 2: writes to 0x20/0x18/0x10 with data in FIFO order, and done_o delayed by 1 cycle.
REQ-035 SHALL cover len=0: done_o in cycle 1 with no mem, FIFO or strobe activity.
REQ-036 SHALL cover a load with load_fifo_almostfull_i held high for cycles 2-4: no mem_re_o in those cycles, exactly len writebacks in total, and addresses contiguous.
REQ-037 SHALL cover wrap-around with base=0xFFFFFFFC, stride=4, len=2: addresses 0xFFFFFFFC then 0x00000000.
REQ-038 SHALL cover reset asserted in cycle 3 of a len=8 load: all strobes 0 from cycle 4, no done_o, and a new start accepted.
